// File: rtl/orv64_amo_seq.sv
// RV64A atomic sequencer: serializes one AMO into fence / load / ALU / store on the D$ port.
// Owns the D$ request port only while busy; ordinary loads and stores bypass it.
module orv64_amo_seq #(
    parameter int XLEN    = 64,
    parameter int VADDR_W = 39
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               amo_req_valid,
    output logic               amo_req_ready,
    input  logic [3:0]         amo_op,
    input  logic               amo_is_w,
    input  logic               amo_aq,
    input  logic               amo_rl,
    input  logic [VADDR_W-1:0] amo_addr,
    input  logic [XLEN-1:0]    amo_wdata,
    input  logic               amo_kill,
    output logic               dc_req_valid,
    input  logic               dc_req_ready,
    output logic               dc_req_re,
    output logic               dc_req_we,
    output logic               dc_req_aq_rl,
    output logic               dc_req_amo_load,
    output logic               dc_req_amo_store,
    output logic [VADDR_W-1:0] dc_req_addr,
    output logic [XLEN-1:0]    dc_req_wdata,
    output logic [7:0]         dc_req_mask,
    input  logic               dc_resp_valid,
    input  logic [XLEN-1:0]    dc_resp_rdata,
    input  logic               dc_resp_excp,
    output logic               amo_done,
    output logic [XLEN-1:0]    amo_ld_data,
    output logic               amo_excp,
    output logic               amo_excp_misaligned,
    output logic               busy
);

    localparam int HW = XLEN / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FENCE_REQ,
        S_FENCE_WAIT,
        S_LD_REQ,
        S_LD_WAIT,
        S_ST_REQ,
        S_ST_WAIT,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [3:0]         op_q;
    logic               is_w_q;
    logic [VADDR_W-1:0] addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [XLEN-1:0]    st_data_q;
    logic [XLEN-1:0]    ld_data_q;
    logic               abort_q;
    logic               excp_q;
    logic               misal_q;

    logic accept;
    logic misaligned;
    logic aborting;
    logic [7:0] mask;

    assign accept     = amo_req_valid && (state == S_IDLE);
    assign misaligned = amo_is_w ? (amo_addr[1:0] != 2'b00) : (amo_addr[2:0] != 3'b000);
    // A kill arriving together with the response still counts as an abort.
    assign aborting   = abort_q | amo_kill;
    assign mask       = !is_w_q ? 8'hFF : (addr_q[2] ? 8'hF0 : 8'h0F);

    // Word operands are sign-extended to XLEN: signed and unsigned orderings
    // both survive the extension, so one 64-bit comparator serves .W and .D.
    logic [HW-1:0]   old_w;
    logic [XLEN-1:0] opa, opb, alu_r, new_val;
    logic            lt_s, lt_u;

    always_comb begin
        old_w = addr_q[2] ? dc_resp_rdata[XLEN-1:HW] : dc_resp_rdata[HW-1:0];
        opa   = is_w_q ? {{HW{old_w[HW-1]}}, old_w} : dc_resp_rdata;
        opb   = is_w_q ? {{HW{wdata_q[HW-1]}}, wdata_q[HW-1:0]} : wdata_q;
        lt_s  = $signed(opa) < $signed(opb);
        lt_u  = opa < opb;
        alu_r = opb;
        case (op_q)
            4'd1:    alu_r = opa + opb;
            4'd2:    alu_r = opa ^ opb;
            4'd3:    alu_r = opa & opb;
            4'd4:    alu_r = opa | opb;
            4'd5:    alu_r = lt_s ? opa : opb;
            4'd6:    alu_r = lt_s ? opb : opa;
            4'd7:    alu_r = lt_u ? opa : opb;
            4'd8:    alu_r = lt_u ? opb : opa;
            default: alu_r = opb;
        endcase
        new_val = is_w_q ? {alu_r[HW-1:0], alu_r[HW-1:0]} : alu_r;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n             = state;
        amo_req_ready       = 1'b0;
        dc_req_valid        = 1'b0;
        dc_req_re           = 1'b0;
        dc_req_we           = 1'b0;
        dc_req_aq_rl        = 1'b0;
        dc_req_amo_load     = 1'b0;
        dc_req_amo_store    = 1'b0;
        dc_req_addr         = '0;
        dc_req_wdata        = '0;
        dc_req_mask         = 8'h00;
        amo_done            = 1'b0;
        amo_excp            = 1'b0;
        amo_excp_misaligned = 1'b0;
        case (state)
            S_IDLE: begin
                amo_req_ready = 1'b1;
                if (accept) begin
                    if (misaligned)             state_n = S_DONE;
                    else if (amo_aq || amo_rl)  state_n = S_FENCE_REQ;
                    else                        state_n = S_LD_REQ;
                end
            end
            S_FENCE_REQ: begin
                dc_req_valid = 1'b1;
                dc_req_aq_rl = 1'b1;
                dc_req_addr  = addr_q;
                if (dc_req_ready)  state_n = S_FENCE_WAIT;
                else if (amo_kill) state_n = S_IDLE;
            end
            S_FENCE_WAIT: begin
                if (dc_resp_valid) state_n = aborting ? S_IDLE : S_LD_REQ;
            end
            S_LD_REQ: begin
                dc_req_valid    = 1'b1;
                dc_req_re       = 1'b1;
                dc_req_amo_load = 1'b1;
                dc_req_addr     = addr_q;
                dc_req_mask     = mask;
                if (dc_req_ready)  state_n = S_LD_WAIT;
                else if (amo_kill) state_n = S_IDLE;
            end
            S_LD_WAIT: begin
                if (dc_resp_valid) begin
                    if (aborting)          state_n = S_IDLE;
                    else if (dc_resp_excp) state_n = S_DONE;
                    else                   state_n = S_ST_REQ;
                end
            end
            S_ST_REQ: begin
                dc_req_valid     = 1'b1;
                dc_req_we        = 1'b1;
                dc_req_amo_store = 1'b1;
                dc_req_addr      = addr_q;
                dc_req_wdata     = st_data_q;
                dc_req_mask      = mask;
                if (dc_req_ready) state_n = S_ST_WAIT;
            end
            S_ST_WAIT: begin
                if (dc_resp_valid) state_n = S_DONE;
            end
            S_DONE: begin
                amo_done            = 1'b1;
                amo_excp            = excp_q;
                amo_excp_misaligned = misal_q;
                state_n             = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 4'd0;
            is_w_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            st_data_q <= '0;
            ld_data_q <= '0;
            abort_q   <= 1'b0;
            excp_q    <= 1'b0;
            misal_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= amo_op;
                is_w_q  <= amo_is_w;
                addr_q  <= amo_addr;
                wdata_q <= amo_wdata;
                abort_q <= 1'b0;
                excp_q  <= misaligned;
                misal_q <= misaligned;
            end
            case (state)
                S_FENCE_REQ, S_LD_REQ: if (amo_kill && dc_req_ready) abort_q <= 1'b1;
                S_FENCE_WAIT:          if (amo_kill) abort_q <= 1'b1;
                S_LD_WAIT: begin
                    if (amo_kill) abort_q <= 1'b1;
                    if (dc_resp_valid && !aborting) begin
                        ld_data_q <= opa;
                        st_data_q <= new_val;
                        excp_q    <= dc_resp_excp;
                    end
                end
                S_ST_WAIT: if (dc_resp_valid) excp_q <= dc_resp_excp;
                default: ;
            endcase
        end
    end

    assign amo_ld_data = ld_data_q;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_orv64_amo_seq.sv
// Directed bench for orv64_amo_seq: lockstep D$ responder driven on the falling edge.
module tb_orv64_amo_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        amo_req_valid, amo_req_ready;
    logic [3:0]  amo_op;
    logic        amo_is_w, amo_aq, amo_rl;
    logic [38:0] amo_addr;
    logic [63:0] amo_wdata;
    logic        amo_kill;
    logic        dc_req_valid, dc_req_ready, dc_req_re, dc_req_we, dc_req_aq_rl;
    logic        dc_req_amo_load, dc_req_amo_store;
    logic [38:0] dc_req_addr;
    logic [63:0] dc_req_wdata;
    logic [7:0]  dc_req_mask;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_rdata;
    logic        dc_resp_excp;
    logic        amo_done;
    logic [63:0] amo_ld_data;
    logic        amo_excp, amo_excp_misaligned, busy;

    int total = 0;
    int bad   = 0;
    int n_fence = 0, n_ld = 0, n_st = 0, n_vld = 0, n_done = 0;

    always #5 clk = ~clk;

    orv64_amo_seq #(.XLEN(64), .VADDR_W(39)) dut (
        .clk(clk), .rst(rst),
        .amo_req_valid(amo_req_valid), .amo_req_ready(amo_req_ready),
        .amo_op(amo_op), .amo_is_w(amo_is_w), .amo_aq(amo_aq), .amo_rl(amo_rl),
        .amo_addr(amo_addr), .amo_wdata(amo_wdata), .amo_kill(amo_kill),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_re(dc_req_re), .dc_req_we(dc_req_we), .dc_req_aq_rl(dc_req_aq_rl),
        .dc_req_amo_load(dc_req_amo_load), .dc_req_amo_store(dc_req_amo_store),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_mask(dc_req_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata), .dc_resp_excp(dc_resp_excp),
        .amo_done(amo_done), .amo_ld_data(amo_ld_data), .amo_excp(amo_excp),
        .amo_excp_misaligned(amo_excp_misaligned), .busy(busy)
    );

    // Traffic counters, sampled on the active edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (dc_req_valid && dc_req_ready) begin
                if (dc_req_aq_rl) n_fence <= n_fence + 1;
                if (dc_req_re)    n_ld    <= n_ld + 1;
                if (dc_req_we)    n_st    <= n_st + 1;
            end
            if (dc_req_valid) n_vld  <= n_vld + 1;
            if (amo_done)     n_done <= n_done + 1;
        end
    end

    task automatic present(input [3:0] op, input w, input aq, input rl, input [38:0] a, input [63:0] wd);
        amo_req_valid = 1'b1; amo_op = op; amo_is_w = w; amo_aq = aq; amo_rl = rl;
        amo_addr = a; amo_wdata = wd;
    endtask

    // Stimulus only: full no-fence AMO in lockstep, returning what was observed.
    task automatic drive_amo(input [3:0] op, input w, input [38:0] a, input [63:0] wd, input [63:0] rd,
                             output logic [63:0] st_wd, output logic [7:0] st_m,
                             output logic [63:0] ld, output logic done_seen);
        present(op, w, 1'b0, 1'b0, a, wd);
        @(negedge clk); amo_req_valid = 1'b0; dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_rdata = rd;
        @(negedge clk); dc_resp_valid = 1'b0;
        st_wd = dc_req_wdata; st_m = dc_req_mask; ld = amo_ld_data; dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
        @(negedge clk); dc_resp_valid = 1'b0; done_seen = amo_done;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (amo_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", amo_req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL reset_dc_valid got=%b exp=0", dc_req_valid); end
        total++; if (amo_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", amo_done); end
        total++; if (amo_ld_data !== 64'h0) begin bad++; $display("FAIL reset_ld_data got=%h exp=0", amo_ld_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_d;
        int f0, d0;
        f0 = n_fence; d0 = n_done;
        present(4'd1, 1'b0, 1'b0, 1'b0, 39'h1000, 64'd3);
        total++; if (amo_req_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", amo_req_ready); end
        @(negedge clk); amo_req_valid = 1'b0;
        total++; if ({dc_req_valid, dc_req_re, dc_req_amo_load, dc_req_aq_rl} !== 4'b1110) begin bad++; $display("FAIL add_ld_req got=%b exp=1110", {dc_req_valid, dc_req_re, dc_req_amo_load, dc_req_aq_rl}); end
        total++; if (dc_req_addr !== 39'h1000) begin bad++; $display("FAIL add_ld_addr got=%h exp=1000", dc_req_addr); end
        total++; if (dc_req_mask !== 8'hFF) begin bad++; $display("FAIL add_ld_mask got=%h exp=ff", dc_req_mask); end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0;
        total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL add_wait_valid got=%b exp=0", dc_req_valid); end
        dc_resp_valid = 1'b1; dc_resp_rdata = 64'd5;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if ({dc_req_valid, dc_req_we, dc_req_amo_store} !== 3'b111) begin bad++; $display("FAIL add_st_req got=%b exp=111", {dc_req_valid, dc_req_we, dc_req_amo_store}); end
        total++; if (dc_req_wdata !== 64'd8) begin bad++; $display("FAIL add_st_wdata got=%h exp=8", dc_req_wdata); end
        total++; if (dc_req_mask !== 8'hFF) begin bad++; $display("FAIL add_st_mask got=%h exp=ff", dc_req_mask); end
        total++; if (amo_ld_data !== 64'd5) begin bad++; $display("FAIL add_ld_data got=%h exp=5", amo_ld_data); end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if ({amo_done, amo_excp} !== 2'b10) begin bad++; $display("FAIL add_done got=%b exp=10", {amo_done, amo_excp}); end
        @(negedge clk);
        total++; if (amo_done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b exp=0", amo_done); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL add_done_count got=%0d exp=1", n_done - d0); end
        total++; if (n_fence - f0 !== 0) begin bad++; $display("FAIL add_no_fence got=%0d exp=0", n_fence - f0); end
    endtask

    task automatic test_min_w_aq;
        int f0;
        f0 = n_fence;
        present(4'd5, 1'b1, 1'b1, 1'b0, 39'h1004, 64'd1);
        @(negedge clk); amo_req_valid = 1'b0;
        total++; if ({dc_req_valid, dc_req_aq_rl, dc_req_re, dc_req_we} !== 4'b1100) begin bad++; $display("FAIL minw_fence_req got=%b exp=1100", {dc_req_valid, dc_req_aq_rl, dc_req_re, dc_req_we}); end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if ({dc_req_valid, dc_req_re} !== 2'b11) begin bad++; $display("FAIL minw_ld_req got=%b exp=11", {dc_req_valid, dc_req_re}); end
        total++; if (dc_req_mask !== 8'hF0) begin bad++; $display("FAIL minw_ld_mask got=%h exp=f0", dc_req_mask); end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_rdata = 64'hFFFFFFFF_12345678;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if (dc_req_wdata !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("FAIL minw_st_wdata got=%h exp=ffffffffffffffff", dc_req_wdata); end
        total++; if (dc_req_mask !== 8'hF0) begin bad++; $display("FAIL minw_st_mask got=%h exp=f0", dc_req_mask); end
        total++; if (amo_ld_data !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("FAIL minw_ld_data got=%h exp=ffffffffffffffff", amo_ld_data); end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if (amo_done !== 1'b1) begin bad++; $display("FAIL minw_done got=%b exp=1", amo_done); end
        @(negedge clk);
        total++; if (n_fence - f0 !== 1) begin bad++; $display("FAIL minw_fence_count got=%0d exp=1", n_fence - f0); end
    endtask

    task automatic test_misaligned;
        int v0;
        logic got, mis, ex;
        v0 = n_vld; got = 1'b0; mis = 1'b0; ex = 1'b0;
        present(4'd0, 1'b0, 1'b0, 1'b0, 39'h1003, 64'h77);
        @(negedge clk); amo_req_valid = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            if (amo_done) begin got = 1'b1; mis = amo_excp_misaligned; ex = amo_excp; end
            else @(negedge clk);
        end
        repeat (2) @(negedge clk);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL mis_done got=%b exp=1", got); end
        total++; if ({ex, mis} !== 2'b11) begin bad++; $display("FAIL mis_excp got=%b exp=11", {ex, mis}); end
        total++; if (n_vld - v0 !== 0) begin bad++; $display("FAIL mis_no_traffic got=%0d exp=0", n_vld - v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_idle got=%b exp=0", busy); end
    endtask

    task automatic test_stall;
        int l0;
        l0 = n_ld;
        present(4'd2, 1'b0, 1'b0, 1'b0, 39'h2000, 64'h00000000_0000FFFF);
        @(negedge clk); amo_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if ({dc_req_valid, dc_req_re} !== 2'b11) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=11", i, {dc_req_valid, dc_req_re}); end
            total++; if (dc_req_addr !== 39'h2000) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=2000", i, dc_req_addr); end
            total++; if (dc_req_mask !== 8'hFF) begin bad++; $display("FAIL stall_mask[%0d] got=%h exp=ff", i, dc_req_mask); end
            @(negedge clk);
        end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0;
        total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL stall_one_out got=%b exp=0", dc_req_valid); end
        dc_resp_valid = 1'b1; dc_resp_rdata = 64'h12345678_0000F0F0;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if (dc_req_wdata !== 64'h12345678_00000F0F) begin bad++; $display("FAIL stall_xor got=%h exp=1234567800000f0f", dc_req_wdata); end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; dc_resp_valid = 1'b1;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if (amo_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", amo_done); end
        @(negedge clk);
        total++; if (n_ld - l0 !== 1) begin bad++; $display("FAIL stall_ld_count got=%0d exp=1", n_ld - l0); end
    endtask

    task automatic test_kill_wait;
        int s0, d0;
        s0 = n_st; d0 = n_done;
        present(4'd4, 1'b0, 1'b0, 1'b0, 39'h3000, 64'h1);
        @(negedge clk); amo_req_valid = 1'b0; dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0; amo_kill = 1'b1;
        @(negedge clk); amo_kill = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL kill_drain_busy got=%b exp=1", busy); end
        @(negedge clk); dc_resp_valid = 1'b1; dc_resp_rdata = 64'h55;
        @(negedge clk); dc_resp_valid = 1'b0;
        total++; if ({busy, amo_req_ready} !== 2'b01) begin bad++; $display("FAIL kill_idle got=%b exp=01", {busy, amo_req_ready}); end
        repeat (3) @(negedge clk);
        total++; if (n_st - s0 !== 0) begin bad++; $display("FAIL kill_no_store got=%0d exp=0", n_st - s0); end
        total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL kill_no_done got=%0d exp=0", n_done - d0); end
    endtask

    task automatic test_kill_req;
        int l0;
        l0 = n_ld;
        present(4'd1, 1'b0, 1'b0, 1'b0, 39'h3008, 64'h1);
        @(negedge clk); amo_req_valid = 1'b0; amo_kill = 1'b1;
        @(negedge clk); amo_kill = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL killreq_idle got=%b exp=0", busy); end
        total++; if (n_ld - l0 !== 0) begin bad++; $display("FAIL killreq_no_ld got=%0d exp=0", n_ld - l0); end
    endtask

    task automatic test_ld_excp;
        int s0;
        s0 = n_st;
        present(4'd3, 1'b1, 1'b0, 1'b0, 39'h1000, 64'hF);
        @(negedge clk); amo_req_valid = 1'b0;
        total++; if (dc_req_mask !== 8'h0F) begin bad++; $display("FAIL excp_ld_mask got=%h exp=0f", dc_req_mask); end
        dc_req_ready = 1'b1;
        @(negedge clk); dc_req_ready = 1'b0;
        dc_resp_valid = 1'b1; dc_resp_excp = 1'b1; dc_resp_rdata = 64'h00000000_80000001;
        @(negedge clk); dc_resp_valid = 1'b0; dc_resp_excp = 1'b0;
        total++; if ({amo_done, amo_excp, amo_excp_misaligned} !== 3'b110) begin bad++; $display("FAIL excp_done got=%b exp=110", {amo_done, amo_excp, amo_excp_misaligned}); end
        total++; if (amo_ld_data !== 64'hFFFFFFFF_80000001) begin bad++; $display("FAIL excp_ld_data got=%h exp=ffffffff80000001", amo_ld_data); end
        repeat (2) @(negedge clk);
        total++; if (n_st - s0 !== 0) begin bad++; $display("FAIL excp_no_store got=%0d exp=0", n_st - s0); end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [38:0] a;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [63:0] st;
        logic [7:0]  m;
        logic [63:0] ld;
    } vec_t;

    task automatic test_back_to_back;
        vec_t tbl[8];
        logic [63:0] st_wd, ld;
        logic [7:0]  st_m;
        logic        dn;
        tbl[0] = '{4'd1,  1'b1, 39'h1000, 64'h2,                  64'h00000000_FFFFFFFF, 64'h00000001_00000001, 8'h0F, 64'hFFFFFFFF_FFFFFFFF};
        tbl[1] = '{4'd8,  1'b1, 39'h1004, 64'h7FFFFFFF,           64'h80000000_00000000, 64'h80000000_80000000, 8'hF0, 64'hFFFFFFFF_80000000};
        tbl[2] = '{4'd6,  1'b1, 39'h1000, 64'h7FFFFFFF,           64'h00000000_80000000, 64'h7FFFFFFF_7FFFFFFF, 8'h0F, 64'hFFFFFFFF_80000000};
        tbl[3] = '{4'd7,  1'b0, 39'h2008, 64'hFFFFFFFF_FFFFFFFE,  64'h80000000_00000000, 64'h80000000_00000000, 8'hFF, 64'h80000000_00000000};
        tbl[4] = '{4'd3,  1'b0, 39'h2010, 64'hFF00FF00_FF00FF00,  64'h0F0F0F0F_0F0F0F0F, 64'h0F000F00_0F000F00, 8'hFF, 64'h0F0F0F0F_0F0F0F0F};
        tbl[5] = '{4'd12, 1'b0, 39'h2018, 64'h11223344_55667788,  64'h00000000_0000DEAD, 64'h11223344_55667788, 8'hFF, 64'h00000000_0000DEAD};
        tbl[6] = '{4'd5,  1'b0, 39'h2020, 64'h1,                  64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'hFFFFFFFF_FFFFFFFF};
        tbl[7] = '{4'd4,  1'b1, 39'h1004, 64'hF,                  64'h000000F0_00000000, 64'h000000FF_000000FF, 8'hF0, 64'h00000000_000000F0};
        for (int i = 0; i < 8; i++) begin
            drive_amo(tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, st_wd, st_m, ld, dn);
            total++; if (st_wd !== tbl[i].st) begin bad++; $display("FAIL b2b_wdata[%0d] got=%h exp=%h", i, st_wd, tbl[i].st); end
            total++; if (st_m !== tbl[i].m) begin bad++; $display("FAIL b2b_mask[%0d] got=%h exp=%h", i, st_m, tbl[i].m); end
            total++; if (ld !== tbl[i].ld) begin bad++; $display("FAIL b2b_ld_data[%0d] got=%h exp=%h", i, ld, tbl[i].ld); end
            total++; if (dn !== 1'b1) begin bad++; $display("FAIL b2b_done[%0d] got=%b exp=1", i, dn); end
        end
    endtask

    initial begin
        rst = 1'b1; amo_req_valid = 1'b0; amo_op = 4'd0; amo_is_w = 1'b0; amo_aq = 1'b0; amo_rl = 1'b0;
        amo_addr = '0; amo_wdata = '0; amo_kill = 1'b0; dc_req_ready = 1'b0;
        dc_resp_valid = 1'b0; dc_resp_rdata = '0; dc_resp_excp = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_d();
        test_min_w_aq();
        test_misaligned();
        test_stall();
        test_kill_wait();
        test_kill_req();
        test_ld_excp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
